axil_csr_bank: RTL and testbench

AXIL_CSR_BANK -- requirements
Module: axil_csr_bank

---
 rtl/axil_csr_bank.sv | 194 +++++++++++++++++++
 tb/tb_axil_csr_bank.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_csr_bank.sv
// AXI4-Lite register bank: read/write CSRs, a free-running cycle counter, a VERSION
// constant, and an LED drive taken from register 0. Independent AW/W holding slots.
module axil_csr_bank #(
    parameter int          ADDR_W   = 21,
    parameter int          DATA_W   = 32,
    parameter int          ID_W     = 12,
    parameter int          NUM_REGS = 8,
    parameter int          LED_W    = 8,
    parameter logic [31:0] VERSION  = 32'h0001_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_axil_awvalid,
    output logic                s_axil_awready,
    input  logic [ADDR_W-1:0]   s_axil_awaddr,
    input  logic [2:0]          s_axil_awprot,
    input  logic [ID_W-1:0]     s_axil_awid,
    input  logic                s_axil_wvalid,
    output logic                s_axil_wready,
    input  logic [DATA_W-1:0]   s_axil_wdata,
    input  logic [DATA_W/8-1:0] s_axil_wstrb,
    output logic                s_axil_bvalid,
    input  logic                s_axil_bready,
    output logic [1:0]          s_axil_bresp,
    output logic [ID_W-1:0]     s_axil_bid,
    input  logic                s_axil_arvalid,
    output logic                s_axil_arready,
    input  logic [ADDR_W-1:0]   s_axil_araddr,
    input  logic [2:0]          s_axil_arprot,
    input  logic [ID_W-1:0]     s_axil_arid,
    output logic                s_axil_rvalid,
    input  logic                s_axil_rready,
    output logic [DATA_W-1:0]   s_axil_rdata,
    output logic [1:0]          s_axil_rresp,
    output logic [ID_W-1:0]     s_axil_rid,
    output logic                s_axil_rlast,
    output logic [LED_W-1:0]    LED
);

    localparam int          STRB_W      = DATA_W / 8;
    localparam int          B           = $clog2(STRB_W);
    localparam int          IW          = $clog2(NUM_REGS);
    localparam int          NUM_RW      = NUM_REGS - 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic                ready_en_q;
    logic                aw_full_q;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [ID_W-1:0]     aw_id_q;
    logic                w_full_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic [ID_W-1:0]     bid_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic [ID_W-1:0]     rid_q;
    logic [DATA_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   regs_q [NUM_RW];
    logic [DATA_W-1:0]   regs_d [NUM_RW];

    logic                aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ID_W-1:0]     wr_id;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic [IW-1:0]       wr_idx, rd_idx;
    logic                wr_go, wr_ok, rd_oor;
    logic [DATA_W-1:0]   rdata_d;
    logic [1:0]          rresp_d;
    logic                unused_prot;

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    // ready_en_q holds every ready low until the first edge after reset release
    assign s_axil_awready = ready_en_q && !aw_full_q && !bvalid_q;
    assign s_axil_wready  = ready_en_q && !w_full_q && !bvalid_q;
    assign s_axil_arready = ready_en_q && !rvalid_q;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;
    assign b_hs  = bvalid_q && s_axil_bready;
    assign r_hs  = rvalid_q && s_axil_rready;

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_bid    = bid_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rid    = rid_q;
    assign s_axil_rlast  = rvalid_q;
    assign LED           = regs_q[0][LED_W-1:0];

    // A channel arriving this cycle is used directly so the commit needs no extra cycle
    assign wr_addr = aw_full_q ? aw_addr_q : s_axil_awaddr;
    assign wr_id   = aw_full_q ? aw_id_q : s_axil_awid;
    assign wr_data = w_full_q ? w_data_q : s_axil_wdata;
    assign wr_strb = w_full_q ? w_strb_q : s_axil_wstrb;
    assign wr_go   = !bvalid_q && (aw_full_q || aw_hs) && (w_full_q || w_hs);
    assign wr_idx  = wr_addr[B +: IW];
    assign wr_ok   = ((wr_addr >> (B + IW)) == '0) && (wr_idx < IW'(NUM_RW));

    assign rd_idx  = s_axil_araddr[B +: IW];
    assign rd_oor  = (s_axil_araddr >> (B + IW)) != '0;

    always_comb begin
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_go && wr_ok && wr_idx == IW'(i)) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        if (rd_oor) begin
            rresp_d = RESP_SLVERR;
        end else if (rd_idx == IW'(NUM_REGS - 1)) begin
            rdata_d[31:0] = VERSION;
        end else if (rd_idx == IW'(NUM_REGS - 2)) begin
            rdata_d = cnt_q;
        end else begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (rd_idx == IW'(i)) rdata_d = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            bid_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rid_q      <= '0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
        end else begin
            ready_en_q <= 1'b1;
            cnt_q      <= cnt_q + DATA_W'(1);
            for (int unsigned i = 0; i < NUM_RW; i++) regs_q[i] <= regs_d[i];

            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= s_axil_awaddr;
                aw_id_q   <= s_axil_awid;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end
            // Slots stay occupied until the response is taken; bvalid masks the commit meanwhile
            if (b_hs) begin
                bvalid_q  <= 1'b0;
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
            end
            if (wr_go) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                bid_q    <= wr_id;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
                rid_q    <= s_axil_arid;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_csr_bank.sv
// Directed bench for axil_csr_bank: write/read paths, strobes, errors, backpressure,
// counter, and reset mid-transaction; inputs driven and outputs sampled on negedge.
module tb_axil_csr_bank;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;
    localparam int ID_W   = 12;
    localparam int LED_W  = 8;
    localparam int TMO    = 20;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic                bready = 1'b0, rready = 1'b0;
    logic                awready, wready, arready, bvalid, rvalid, rlast;
    logic [ADDR_W-1:0]   awaddr = '0, araddr = '0;
    logic [2:0]          awprot = '0, arprot = '0;
    logic [ID_W-1:0]     awid = '0, arid = '0, bid, rid;
    logic [DATA_W-1:0]   wdata = '0, rdata;
    logic [DATA_W/8-1:0] wstrb = '0;
    logic [1:0]          bresp, rresp;
    logic [LED_W-1:0]    led;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    axil_csr_bank #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .NUM_REGS(8),
        .LED_W(LED_W), .VERSION(32'h0001_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
        .s_axil_awprot(awprot), .s_axil_awid(awid),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata),
        .s_axil_wstrb(wstrb),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_bid(bid),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
        .s_axil_arprot(arprot), .s_axil_arid(arid),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata),
        .s_axil_rresp(rresp), .s_axil_rid(rid), .s_axil_rlast(rlast),
        .LED(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // AW and W presented together; returns the B response after taking it
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [3:0] s, input logic [ID_W-1:0] id,
                            output logic [1:0] resp, output logic [ID_W-1:0] rbid);
        int t = 0;
        @(negedge clk);
        awvalid = 1'b1; awaddr = a; awid = id;
        wvalid = 1'b1; wdata = d; wstrb = s;
        while (!(awready && wready) && t < TMO) begin @(negedge clk); t++; end
        if (t == TMO) check_eq("wr_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("wr_bvalid", bvalid, 1);
        resp = bresp; rbid = bid;
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        check_eq("wr_bvalid_clr", bvalid, 0);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                           output logic [DATA_W-1:0] d, output logic [1:0] resp,
                           output logic [ID_W-1:0] rrid, output logic last, output int hs_cyc);
        int t = 0;
        @(negedge clk);
        arvalid = 1'b1; araddr = a; arid = id;
        while (!arready && t < TMO) begin @(negedge clk); t++; end
        if (t == TMO) check_eq("rd_ready_timeout", 0, 1);
        hs_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("rd_rvalid", rvalid, 1);
        d = rdata; resp = rresp; rrid = rid; last = rlast;
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        check_eq("rd_rvalid_clr", rvalid, 0);
    endtask

    initial begin
        logic [1:0]        r;
        logic [ID_W-1:0]   i;
        logic [DATA_W-1:0] d;
        logic              l;
        int                c1, c2;

        // Reset state
        #2;
        check_eq("rst_awready", awready, 0);
        check_eq("rst_wready", wready, 0);
        check_eq("rst_arready", arready, 0);
        check_eq("rst_bvalid", bvalid, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_led", led, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 check_eq("rel_awready_pre", awready, 0);
        @(negedge clk);
        check_eq("rel_awready", awready, 1);
        check_eq("rel_wready", wready, 1);
        check_eq("rel_arready", arready, 1);

        // AW+W same cycle to reg0
        do_write(21'h0, 32'h0000_00A5, 4'hF, 12'h123, r, i);
        check_eq("w0_bresp", r, 2'b00);
        check_eq("w0_bid", i, 12'h123);
        check_eq("w0_led", led, 8'hA5);

        // W two cycles ahead of AW, reg1, lane 1 only
        @(negedge clk);
        wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'h2;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        check_eq("wfirst_wready", wready, 0);
        check_eq("wfirst_nob", bvalid, 0);
        @(negedge clk);
        check_eq("wfirst_nob2", bvalid, 0);
        awvalid = 1'b1; awaddr = 21'h4; awid = 12'h456;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        check_eq("wfirst_bvalid", bvalid, 1);
        check_eq("wfirst_bresp", bresp, 2'b00);
        check_eq("wfirst_bid", bid, 12'h456);
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        do_read(21'h4, 12'h05A, d, r, i, l, c1);
        check_eq("r1_data", d, 32'h0000_FF00);
        check_eq("r1_rid", i, 12'h05A);
        check_eq("r1_rlast", l, 1);
        check_eq("r1_rresp", r, 2'b00);

        // Zero strobe: OKAY, nothing written
        do_write(21'h4, 32'h1234_5678, 4'h0, 12'h001, r, i);
        check_eq("strb0_bresp", r, 2'b00);
        do_read(21'h4, 12'h001, d, r, i, l, c1);
        check_eq("strb0_data", d, 32'h0000_FF00);

        // Read-only and out-of-range accesses
        do_write(21'h1C, 32'hDEAD_BEEF, 4'hF, 12'h007, r, i);
        check_eq("wver_bresp", r, 2'b10);
        check_eq("wver_bid", i, 12'h007);
        do_write(21'h18, 32'hDEAD_BEEF, 4'hF, 12'h008, r, i);
        check_eq("wcnt_bresp", r, 2'b10);
        do_write(21'h1000, 32'hDEAD_BEEF, 4'hF, 12'h009, r, i);
        check_eq("woor_bresp", r, 2'b10);
        check_eq("woor_led", led, 8'hA5);
        do_read(21'h1000, 12'h00A, d, r, i, l, c1);
        check_eq("roor_rresp", r, 2'b10);
        check_eq("roor_rdata", d, 0);
        do_read(21'h1C, 12'h00B, d, r, i, l, c1);
        check_eq("rver_data", d, 32'h0001_0000);
        check_eq("rver_rresp", r, 2'b00);
        do_read(21'h0, 12'h00C, d, r, i, l, c1);
        check_eq("r0_after_err", d, 32'h0000_00A5);

        // B backpressure: bvalid held, new AW not taken until B handshake
        @(negedge clk);
        awvalid = 1'b1; awaddr = 21'h8; awid = 12'h0AB;
        wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        awaddr = 21'hC; awid = 12'h0CD;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_bvalid", bvalid, 1);
            check_eq("bp_awready", awready, 0);
            check_eq("bp_wready", wready, 0);
            check_eq("bp_bid", bid, 12'h0AB);
            @(negedge clk);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        check_eq("bp_bvalid_clr", bvalid, 0);
        check_eq("bp_awready_free", awready, 1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        check_eq("bp_aw_taken", awready, 0);
        wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        check_eq("bp2_bvalid", bvalid, 1);
        check_eq("bp2_bid", bid, 12'h0CD);
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        do_read(21'h8, 12'h002, d, r, i, l, c1);
        check_eq("r2_data", d, 32'h1234_5678);
        do_read(21'hC, 12'h003, d, r, i, l, c1);
        check_eq("r3_data", d, 32'hCAFE_F00D);

        // Same-edge write commit and read of reg4 returns the old value
        do_write(21'h10, 32'h1111_1111, 4'hF, 12'h004, r, i);
        @(negedge clk);
        awvalid = 1'b1; awaddr = 21'h10; awid = 12'h005;
        wvalid = 1'b1; wdata = 32'h2222_2222; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 21'h10; arid = 12'h006;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("same_rdata", rdata, 32'h1111_1111);
        check_eq("same_bvalid", bvalid, 1);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        do_read(21'h10, 12'h007, d, r, i, l, c1);
        check_eq("same_new", d, 32'h2222_2222);

        // Counter difference over a known number of cycles
        begin
            logic [DATA_W-1:0] d1;
            do_read(21'h18, 12'h010, d1, r, i, l, c1);
            repeat (7) @(negedge clk);
            do_read(21'h18, 12'h011, d, r, i, l, c2);
            check_eq("cnt_diff", d - d1, DATA_W'(c2 - c1));
        end

        // Reset while AW is held and W is pending
        @(negedge clk);
        awvalid = 1'b1; awaddr = 21'h0; awid = 12'h0EE;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        check_eq("mid_aw_held", awready, 0);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_awready", awready, 0);
        check_eq("mid_rst_arready", arready, 0);
        check_eq("mid_rst_led", led, 0);
        check_eq("mid_rst_bid", bid, 0);
        #1 rst = 1'b0;
        #1 check_eq("mid_rel_wready_pre", wready, 0);
        @(negedge clk);
        check_eq("mid_rel_awready", awready, 1);
        check_eq("mid_rel_wready", wready, 1);
        check_eq("mid_rel_arready", arready, 1);
        repeat (3) begin
            @(negedge clk);
            check_eq("mid_no_b", bvalid, 0);
        end
        do_read(21'h0, 12'h012, d, r, i, l, c1);
        check_eq("mid_reg0", d, 0);
        check_eq("mid_led", led, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
